// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage between ID and MEM. Latches the ID bundle,
// computes the ALU result, drives the DRAM store port one cycle ahead of
// MEM and, with RV32M_DIV_EN defined, runs an iterative restoring divider
// for DIV/DIVU/REM/REMU (without it, div ops return the plain ALU result).
// Ports: clk, rst (sync, active-high); id_to_ex_bus/id_to_ex_valid from ID;
// mem_allow_in from MEM; flush kills EX; ex_allow_in to ID;
// ex_to_mem_valid/ex_to_mem_bus to MEM; ex_to_id_bus forwarding to ID;
// dram_addr/dram_wdin/dram_wstrb to data RAM.
// Bus layouts (MSB first):
//   id_to_ex_bus  {alu_op[3:0], div_en, div_op[1:0], alu_a, alu_b, rs2_data,
//                  st_size[1:0], mem_ext_op[2:0], rf_we, rf_wsel[1:0], pc4,
//                  ext, wb_reg[4:0], csr_rdata}
//   ex_to_mem_bus {mem_ext_op, rf_we, rf_wsel, pc4, ext, wb_reg, alu_c,
//                  csr_rdata}
//   ex_to_id_bus  {ex_valid, rf_we, is_load, wb_reg, alu_c}
module ex_stage #(
    parameter int XLEN                = 32,
    parameter int ID_TO_EX_BUS_WIDTH  = 212,
    parameter int EX_TO_MEM_BUS_WIDTH = 139
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ID_TO_EX_BUS_WIDTH-1:0]  id_to_ex_bus,
    input  logic                           id_to_ex_valid,
    input  logic                           mem_allow_in,
    input  logic                           flush,
    output logic                           ex_allow_in,
    output logic                           ex_to_mem_valid,
    output logic [EX_TO_MEM_BUS_WIDTH-1:0] ex_to_mem_bus,
    output logic [39:0]                    ex_to_id_bus,
    output logic [XLEN-1:0]                dram_addr,
    output logic [XLEN-1:0]                dram_wdin,
    output logic [3:0]                     dram_wstrb
);
    localparam logic [1:0] WB_MEM = 2'd1;

    logic                          ex_valid_q;
    logic [ID_TO_EX_BUS_WIDTH-1:0] bus_q;

    logic [3:0]      alu_op;
    logic            div_en;
    logic [1:0]      div_op;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] rs2_data;
    logic [1:0]      st_size;
    logic [2:0]      mem_ext_op;
    logic            rf_we;
    logic [1:0]      rf_wsel;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] ext;
    logic [4:0]      wb_reg;
    logic [XLEN-1:0] csr_rdata;

    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] alu_c;
    logic            ex_ready_go;
    logic            fire;

    assign {alu_op, div_en, div_op, alu_a, alu_b, rs2_data, st_size,
            mem_ext_op, rf_we, rf_wsel, pc4, ext, wb_reg, csr_rdata} = bus_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_valid_q <= 1'b0;
        end else if (ex_allow_in) begin
            ex_valid_q <= id_to_ex_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q <= '0;
        end else if (ex_allow_in && id_to_ex_valid) begin
            bus_q <= id_to_ex_bus;
        end
    end

    assign ex_allow_in     = !ex_valid_q || (ex_ready_go && mem_allow_in);
    assign ex_to_mem_valid = ex_valid_q && ex_ready_go && !flush;
    assign fire            = ex_to_mem_valid && mem_allow_in;

    // ALU: 0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA 8 OR 9 AND 10 PASS-B
    always_comb begin
        alu_res = alu_a + alu_b;
        case (alu_op)
            4'd1:    alu_res = alu_a - alu_b;
            4'd2:    alu_res = alu_a << alu_b[4:0];
            4'd3:    alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'd4:    alu_res = {31'd0, alu_a < alu_b};
            4'd5:    alu_res = alu_a ^ alu_b;
            4'd6:    alu_res = alu_a >> alu_b[4:0];
            4'd7:    alu_res = $signed(alu_a) >>> alu_b[4:0];
            4'd8:    alu_res = alu_a | alu_b;
            4'd9:    alu_res = alu_a & alu_b;
            4'd10:   alu_res = alu_b;
            default: alu_res = alu_a + alu_b;
        endcase
    end

`ifdef RV32M_DIV_EN
    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;

    div_state_e      state_q;
    logic [4:0]      cnt_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dsor_q;
    logic [XLEN-1:0] res_q;
    logic            qneg_q;
    logic            rneg_q;
    logic            is_rem_q;
    logic            div_done_q;

    logic            sgn;
    logic            is_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN:0]   rem_sh;
    logic            take;
    logic [XLEN-1:0] rem_d;
    logic [XLEN-1:0] quo_d;
    logic [XLEN-1:0] q_fin;
    logic [XLEN-1:0] r_fin;

    assign sgn    = ~div_op[0];
    assign is_rem = div_op[1];
    assign a_neg  = sgn & alu_a[XLEN-1];
    assign b_neg  = sgn & alu_b[XLEN-1];
    assign a_mag  = a_neg ? -alu_a : alu_a;
    assign b_mag  = b_neg ? -alu_b : alu_b;

    // quo_q starts as the dividend and shifts its MSB into the partial
    // remainder each step while quotient bits fill in from the bottom
    assign rem_sh = {rem_q, quo_q[XLEN-1]};
    assign take   = rem_sh >= {1'b0, dsor_q};
    assign rem_d  = take ? rem_sh[XLEN-1:0] - dsor_q : rem_sh[XLEN-1:0];
    assign quo_d  = {quo_q[XLEN-2:0], take};
    assign q_fin  = qneg_q ? -quo_d : quo_d;
    assign r_fin  = rneg_q ? -rem_d : rem_d;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dsor_q     <= '0;
            res_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            is_rem_q   <= 1'b0;
            div_done_q <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (ex_valid_q && div_en && !div_done_q) begin
                        if (alu_b == '0) begin
                            res_q      <= is_rem ? alu_a : '1;
                            div_done_q <= 1'b1;
                            state_q    <= DIV_DONE;
                        end else if (sgn && alu_a == {1'b1, {(XLEN-1){1'b0}}}
                                     && alu_b == '1) begin
                            res_q      <= is_rem ? '0 : alu_a;
                            div_done_q <= 1'b1;
                            state_q    <= DIV_DONE;
                        end else begin
                            quo_q    <= a_mag;
                            rem_q    <= '0;
                            dsor_q   <= b_mag;
                            qneg_q   <= a_neg ^ b_neg;
                            rneg_q   <= a_neg;
                            is_rem_q <= is_rem;
                            cnt_q    <= 5'd31;
                            state_q  <= DIV_RUN;
                        end
                    end
                end
                DIV_RUN: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        res_q      <= is_rem_q ? r_fin : q_fin;
                        div_done_q <= 1'b1;
                        state_q    <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (fire) begin
                        div_done_q <= 1'b0;
                        state_q    <= DIV_IDLE;
                    end
                end
                default: state_q <= DIV_IDLE;
            endcase
        end
    end

    assign ex_ready_go = !div_en || div_done_q;
    assign alu_c       = div_en ? res_q : alu_res;
`else
    logic unused_div;
    assign unused_div  = ^{div_en, div_op};
    assign ex_ready_go = 1'b1;
    assign alu_c       = alu_res;
`endif

    // lanes follow the masked address; misalignment is trapped elsewhere
    always_comb begin
        dram_wstrb = 4'b0000;
        dram_wdin  = rs2_data;
        case (st_size)
            2'b01: begin
                dram_wdin = {4{rs2_data[7:0]}};
                if (fire) dram_wstrb = 4'b0001 << alu_res[1:0];
            end
            2'b10: begin
                dram_wdin = {2{rs2_data[15:0]}};
                if (fire) dram_wstrb = 4'b0011 << {alu_res[1], 1'b0};
            end
            2'b11: begin
                if (fire) dram_wstrb = 4'hF;
            end
            default: dram_wstrb = 4'b0000;
        endcase
    end

    assign dram_addr = {alu_res[XLEN-1:2], 2'b00};

    assign ex_to_mem_bus = {mem_ext_op, rf_we, rf_wsel, pc4, ext, wb_reg,
                            alu_c, csr_rdata};
    assign ex_to_id_bus  = {ex_valid_q, rf_we, rf_wsel == WB_MEM, wb_reg,
                            alu_c};
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors push expected MEM-side
// results; a negedge monitor pops and compares on every fire.
module tb_ex_stage;
    localparam int IW = 212;
    localparam int OW = 139;
`ifdef RV32M_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] id_bus = '0;
    logic          id_valid = 1'b0;
    logic          mem_allow_in = 1'b1;
    logic          flush = 1'b0;
    logic          ex_allow_in;
    logic          ex_to_mem_valid;
    logic [OW-1:0] ex_to_mem_bus;
    logic [39:0]   ex_to_id_bus;
    logic [31:0]   dram_addr;
    logic [31:0]   dram_wdin;
    logic [3:0]    dram_wstrb;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .id_to_ex_bus    (id_bus),
        .id_to_ex_valid  (id_valid),
        .mem_allow_in    (mem_allow_in),
        .flush           (flush),
        .ex_allow_in     (ex_allow_in),
        .ex_to_mem_valid (ex_to_mem_valid),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_id_bus    (ex_to_id_bus),
        .dram_addr       (dram_addr),
        .dram_wdin       (dram_wdin),
        .dram_wstrb      (dram_wstrb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] c;
        logic [4:0]  wb;
        logic [31:0] csr;
        logic [3:0]  st;
        logic [31:0] wd;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    // back-to-back ALU vectors
    logic [3:0]  t_op [5] = '{4'd1, 4'd2, 4'd7, 4'd4, 4'd5};
    logic [31:0] t_a  [5] = '{32'd3, 32'd1, 32'h80000000, 32'd1, 32'hF0F0F0F0};
    logic [31:0] t_b  [5] = '{32'd5, 32'd4, 32'd4, 32'hFFFFFFFF, 32'hFF00FF00};
    logic [31:0] t_c  [5] = '{32'hFFFFFFFE, 32'h10, 32'hF8000000, 32'd1,
                              32'h0FF00FF0};

    // divide vectors: op, operands, divider result, plain ADD result, cycles
    logic [1:0]  d_op [9] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b01, 2'b10,
                              2'b00, 2'b10, 2'b00};
    logic [31:0] d_a  [9] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                              32'd5, 32'h80000000, 32'h80000000,
                              32'hFFFFFFF9, 32'd7};
    logic [31:0] d_b  [9] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,
                              32'hFFFFFFFE};
    logic [31:0] d_q  [9] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                              32'hFFFFFFFF, 32'd0, 32'h80000000,
                              32'hFFFFFFF9, 32'hFFFFFFFD};
    logic [31:0] d_n  [9] = '{32'hFFFFFFFB, 32'hFFFFFFFB, 32'd107, 32'd107,
                              32'd5, 32'h7FFFFFFF, 32'h7FFFFFFF,
                              32'hFFFFFFF9, 32'd5};
    int          d_cyc [9] = '{34, 34, 34, 34, 2, 2, 2, 2, 34};

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [IW-1:0] mk(
        input logic [3:0] op, input logic den, input logic [1:0] dop,
        input logic [31:0] a, input logic [31:0] b, input logic [31:0] rs2,
        input logic [1:0] st, input logic [4:0] wb, input logic [31:0] csr);
        return {op, den, dop, a, b, rs2, st, 3'd0, (st == 2'b00), 2'd0,
                32'h4, 32'h0, wb, csr};
    endfunction

    task automatic push_exp(input logic [31:0] c, input logic [4:0] wb,
                            input logic [31:0] csr, input logic [3:0] st,
                            input logic [31:0] wd);
        exp_t e;
        e.c   = c;
        e.wb  = wb;
        e.csr = csr;
        e.st  = st;
        e.wd  = wd;
        exp_q.push_back(e);
    endtask

    // present one instruction; returns at posedge+1 after acceptance
    task automatic send(input logic [IW-1:0] b, output int n);
        n = 0;
        id_bus   = b;
        id_valid = 1'b1;
        @(negedge clk);
        while (!ex_allow_in && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: ex_allow_in stayed 0");
        end
        @(posedge clk);
        #1;
        id_valid = 1'b0;
    endtask

    // cycles in EX until ex_to_mem_valid, and cycles allow_in was high early
    task automatic wait_fire(output int cyc, output int ahi);
        cyc = 0;
        ahi = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!ex_to_mem_valid && ex_allow_in) ahi++;
        end while (!ex_to_mem_valid && cyc < 100);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && ex_to_mem_valid && mem_allow_in) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_fire: alu_c %0h with empty queue",
                             ex_to_mem_bus[63:32]);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_alu_c", ex_to_mem_bus[63:32], e.c);
                    chk("sb_wb_reg", ex_to_mem_bus[68:64], e.wb);
                    chk("sb_csr", ex_to_mem_bus[31:0], e.csr);
                    chk("sb_wstrb", dram_wstrb, e.st);
                    chk("sb_wdin", dram_wdin, e.wd);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        int cyc;
        int ahi;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_allow_in", ex_allow_in, 1);
        chk("rst_to_mem_valid", ex_to_mem_valid, 0);
        chk("rst_wstrb", dram_wstrb, 0);
        chk("rst_fwd_valid", ex_to_id_bus[39], 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        push_exp(32'd12, 5'd3, 32'h11, 4'b0, 32'd0);
        send(mk(4'd0, 1'b0, 2'b00, 32'd5, 32'd7, 32'd0, 2'b00, 5'd3,
                32'h11), n);
        @(negedge clk);
        chk("add_one_cycle", ex_to_mem_valid, 1);
        chk("add_fwd_bus", ex_to_id_bus, {1'b1, 1'b1, 1'b0, 5'd3, 32'd12});
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            push_exp(t_c[i], 5'(4 + i), 32'(i), 4'b0, 32'd0);
            send(mk(t_op[i], 1'b0, 2'b00, t_a[i], t_b[i], 32'd0, 2'b00,
                    5'(4 + i), 32'(i)), n);
            chk($sformatf("b2b%0d_no_stall", i), n, 0);
        end
        repeat (2) @(posedge clk);
        #1;

        push_exp(32'h1003, 5'd0, 32'd0, 4'b1000, 32'hABABABAB);
        send(mk(4'd0, 1'b0, 2'b00, 32'h1000, 32'd3, 32'hAB, 2'b01, 5'd0,
                32'd0), n);
        @(negedge clk);
        chk("sb_addr", dram_addr, 32'h1000);
        chk("sb_strobe", dram_wstrb, 4'b1000);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("sb_strobe_after", dram_wstrb, 0);
        @(posedge clk);
        #1;

        push_exp(32'h2002, 5'd0, 32'd0, 4'b1100, 32'hABCDABCD);
        send(mk(4'd0, 1'b0, 2'b00, 32'h2000, 32'd2, 32'h1234ABCD, 2'b10,
                5'd0, 32'd0), n);
        wait_fire(cyc, ahi);
        chk("sh_cycles", cyc, 1);

        if (!DIV_ON) push_exp(32'd107, 5'd9, 32'd0, 4'b0, 32'd0);
        send(mk(4'd0, 1'b1, 2'b01, 32'd100, 32'd7, 32'd0, 2'b00, 5'd9,
                32'd0), n);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_ex_valid", ex_to_id_bus[39], 0);
        chk("flush_allow_in", ex_allow_in, 1);
        @(posedge clk);
        #1;

        push_exp(32'd42, 5'd10, 32'd0, 4'b0, 32'd0);
        send(mk(4'd0, 1'b0, 2'b00, 32'd20, 32'd22, 32'd0, 2'b00, 5'd10,
                32'd0), n);
        wait_fire(cyc, ahi);
        chk("post_flush_add_cycles", cyc, 1);

        for (int i = 0; i < 9; i++) begin
            push_exp(DIV_ON ? d_q[i] : d_n[i], 5'(12 + i), 32'd0, 4'b0,
                     32'd0);
            send(mk(4'd0, 1'b1, d_op[i], d_a[i], d_b[i], 32'd0, 2'b00,
                    5'(12 + i), 32'd0), n);
            wait_fire(cyc, ahi);
            chk($sformatf("div%0d_cycles", i), cyc, DIV_ON ? d_cyc[i] : 1);
            chk($sformatf("div%0d_allow_low", i), ahi, 0);
        end

        mem_allow_in = 1'b0;
        push_exp(32'h3000, 5'd0, 32'd0, 4'hF, 32'hDEADBEEF);
        send(mk(4'd0, 1'b0, 2'b00, 32'h3000, 32'd0, 32'hDEADBEEF, 2'b11,
                5'd0, 32'd0), n);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("sw_stall%0d_wstrb", i), dram_wstrb, 0);
            chk($sformatf("sw_stall%0d_bus", i), ex_to_mem_bus[63:32],
                32'h3000);
            chk($sformatf("sw_stall%0d_allow", i), ex_allow_in, 0);
            @(posedge clk);
            #1;
        end
        mem_allow_in = 1'b1;
        @(negedge clk);
        chk("sw_release_wstrb", dram_wstrb, 4'hF);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("sw_after_wstrb", dram_wstrb, 0);
        @(posedge clk);
        #1;

        id_bus   = mk(4'd0, 1'b0, 2'b00, 32'd1, 32'd1, 32'd0, 2'b00, 5'd1,
                      32'd0);
        id_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        id_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        chk("flush_in_discard", ex_to_id_bus[39], 0);
        chk("flush_in_no_valid", ex_to_mem_valid, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
